// File: rtl/hack_mem_pkg.sv
// Shared constants, FSM state encoding and bank-select width helper for the banked Hack data RAM.
package hack_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_BANKS  = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Number of address bits that select a bank; zero when there is only one bank.
    function automatic int bank_sel_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 0;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One bank of the banked RAM: single-port storage with write enable and a registered read
// that only updates on a read enable, so the last result is held between reads.
module ram_bank #(
    parameter int DATA_W = 16,
    parameter int OFF_W  = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << OFF_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[offset] <= wdata;
        end
        if (re) begin
            rdata <= mem[offset];
        end
    end

endmodule

// File: rtl/banked_ram.sv
// Banked synchronous single-port RAM with registered read, valid strobe and a zero-fill sequencer.
// Optional build macro BANKED_RAM_WRITE_ECHO_EN: IDLE writes also drive out = in and pulse out_valid.
module banked_ram
    import hack_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANKS  = DEF_BANKS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              clr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam int SEL_W     = bank_sel_w(BANKS);
    localparam int SEL_VW    = (SEL_W > 0) ? SEL_W : 1;
    localparam int OFF_W     = ADDR_W - SEL_W;
    localparam int OFF_VW    = (OFF_W > 0) ? OFF_W : 1;
    localparam int FILL_LAST = (1 << OFF_W) - 1;

    state_t state_q, state_d;
    logic [OFF_VW-1:0] cnt_q, cnt_d;

    logic [SEL_VW-1:0] bank_sel;
    logic [OFF_VW-1:0] offset;

    logic              idle;
    logic              fill;
    logic              rd_fire;
    logic              wr_fire;

    logic [BANKS-1:0]  bank_hit;
    logic [BANKS-1:0]  bank_we;
    logic [BANKS-1:0]  bank_re;
    logic [OFF_VW-1:0] bank_off;
    logic [DATA_W-1:0] bank_wdata;
    logic [DATA_W-1:0] bank_rdata [BANKS];

    logic [SEL_VW-1:0] bank_p1;
    logic              src_bank_p1;
    logic              vld_p1;

    // Address split: top bits pick the bank, the remainder is the in-bank offset.
    generate
        if (SEL_W == 0) begin : g_one_bank
            assign bank_sel = '0;
        end else begin : g_multi_bank
            assign bank_sel = address[ADDR_W-1 -: SEL_W];
        end
        if (OFF_W == 0) begin : g_no_off
            assign offset = '0;
        end else begin : g_off
            assign offset = address[OFF_W-1:0];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == OFF_VW'(FILL_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + OFF_VW'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign idle    = (state_q == IDLE);
    assign busy    = (state_q == CLEAR);
    assign fill    = busy && !RST;
    assign rd_fire = idle && en && !load;
    assign wr_fire = idle && en && load;

    // Stage p0: bank decode; the fill writes every bank at once, accesses touch only the selected one.
    assign bank_off   = fill ? cnt_q : offset;
    assign bank_wdata = fill ? '0 : in;

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            assign bank_hit[b] = (bank_sel == SEL_VW'(b));
            assign bank_we[b]  = fill || (wr_fire && bank_hit[b]);
            assign bank_re[b]  = rd_fire && bank_hit[b];

            ram_bank #(
                .DATA_W (DATA_W),
                .OFF_W  (OFF_VW)
            ) u_bank (
                .clk    (CLK),
                .we     (bank_we[b]),
                .re     (bank_re[b]),
                .offset (bank_off),
                .wdata  (bank_wdata),
                .rdata  (bank_rdata[b])
            );
        end
    endgenerate

    // Stage p1: remember which bank answered so the output mux follows the registered read.
    always_ff @(posedge CLK) begin
        if (rd_fire) begin
            bank_p1 <= bank_sel;
        end
    end

`ifdef BANKED_RAM_WRITE_ECHO_EN
    logic [DATA_W-1:0] echo_p1;
    logic              src_echo_p1;

    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            echo_p1 <= in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            src_bank_p1 <= 1'b0;
            src_echo_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= rd_fire || wr_fire;
            if (rd_fire) begin
                src_bank_p1 <= 1'b1;
                src_echo_p1 <= 1'b0;
            end else if (wr_fire) begin
                src_bank_p1 <= 1'b0;
                src_echo_p1 <= 1'b1;
            end
        end
    end

    always_comb begin
        out = '0;
        if (src_bank_p1) begin
            out = bank_rdata[bank_p1];
        end else if (src_echo_p1) begin
            out = echo_p1;
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (RST) begin
            src_bank_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= rd_fire;
            if (rd_fire) begin
                src_bank_p1 <= 1'b1;
            end
        end
    end

    // Bank read registers hold between reads, so the muxed word is stable until the next read.
    always_comb begin
        out = '0;
        if (src_bank_p1) begin
            out = bank_rdata[bank_p1];
        end
    end
`endif

    assign out_valid = vld_p1;

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram with default parameters (16-bit words, 14-bit address, 4 banks).
module tb_banked_ram;

    logic        CLK;
    logic        RST;
    logic        en;
    logic        load;
    logic [13:0] address;
    logic [15:0] in;
    logic        clr;
    logic [15:0] out;
    logic        out_valid;
    logic        busy;

    int checks;
    int errors;

    banked_ram #(
        .DATA_W (16),
        .ADDR_W (14),
        .BANKS  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .en        (en),
        .load      (load),
        .address   (address),
        .in        (in),
        .clr       (clr),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d);
        en = 1'b1; load = 1'b1; address = a; in = d;
        tick();
        en = 1'b0; load = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] a, input logic [15:0] exp);
        en = 1'b1; load = 1'b0; address = a;
        tick();
        en = 1'b0;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk(tag, {16'd0, out}, {16'd0, exp});
    endtask

    // Counts edges until busy drops; quiet flags any out/out_valid activity during the fill.
    task automatic count_fill(output int n, output logic quiet, input logic check_out_zero);
        n = 0;
        quiet = 1'b1;
        while (busy && n < 5000) begin
            tick();
            n++;
            if (out_valid) quiet = 1'b0;
            if (check_out_zero && out !== 16'h0000) quiet = 1'b0;
        end
    endtask

    int   n;
    logic quiet;

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1; en = 1'b0; load = 1'b0; address = '0; in = '0; clr = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_vld", {31'd0, out_valid}, 32'd0);

        RST = 1'b0;
        count_fill(n, quiet, 1'b1);
        chk("fill_len", n, 32'd4096);
        chk("fill_quiet", {31'd0, quiet}, 32'd1);

        rd_chk("rd_3fff", 14'h3FFF, 16'h0000);
        tick();
        chk("vld_drop", {31'd0, out_valid}, 32'd0);

        // Bank isolation
        wr(14'h0005, 16'h1234);
        wr(14'h1005, 16'hBEEF);
        wr(14'h2005, 16'hCAFE);
        wr(14'h3005, 16'h0F0F);
        rd_chk("iso_0005", 14'h0005, 16'h1234);
        rd_chk("iso_2005", 14'h2005, 16'hCAFE);
        rd_chk("iso_3005", 14'h3005, 16'h0F0F);
        rd_chk("iso_0006", 14'h0006, 16'h0000);
        rd_chk("iso_1005", 14'h1005, 16'hBEEF);

        // Write echo (or its absence) while out holds 0xBEEF
        wr(14'h0010, 16'h7E7E);
`ifdef BANKED_RAM_WRITE_ECHO_EN
        chk("echo_out", {16'd0, out}, 32'h7E7E);
        chk("echo_vld", {31'd0, out_valid}, 32'd1);
`else
        chk("echo_out", {16'd0, out}, 32'hBEEF);
        chk("echo_vld", {31'd0, out_valid}, 32'd0);
`endif
        rd_chk("echo_rd", 14'h0010, 16'h7E7E);

        // Back-to-back
        wr(14'h0100, 16'hAAAA);
        en = 1'b1; load = 1'b0; address = 14'h0100;
        tick();
        chk("b2b_vld0", {31'd0, out_valid}, 32'd1);
        chk("b2b_out0", {16'd0, out}, 32'hAAAA);
        address = 14'h0101;
        tick();
        en = 1'b0;
        chk("b2b_vld1", {31'd0, out_valid}, 32'd1);
        chk("b2b_out1", {16'd0, out}, 32'h0000);
        tick();
        chk("b2b_vld2", {31'd0, out_valid}, 32'd0);

        // clr with same-cycle read; a write issued mid-fill to an already-cleared offset must be dropped
        wr(14'h2000, 16'h5555);
        en = 1'b1; load = 1'b0; address = 14'h2000; clr = 1'b1;
        tick();
        en = 1'b0; clr = 1'b0;
        chk("clr_out", {16'd0, out}, 32'h5555);
        chk("clr_vld", {31'd0, out_valid}, 32'd1);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        n = 0;
        quiet = 1'b1;
        while (busy && n < 5000) begin
            if (n == 10) begin
                en = 1'b1; load = 1'b1; address = 14'h0003; in = 16'h9999;
            end else begin
                en = 1'b0; load = 1'b0;
            end
            tick();
            n++;
            if (out_valid) quiet = 1'b0;
        end
        en = 1'b0; load = 1'b0;
        chk("clr_len", n, 32'd4096);
        chk("clr_quiet", {31'd0, quiet}, 32'd1);
        rd_chk("clr_2000", 14'h2000, 16'h0000);
        rd_chk("clr_0005", 14'h0005, 16'h0000);
        rd_chk("drop_0003", 14'h0003, 16'h0000);

        // Reset in the middle of a fill
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 999; i++) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd1);
        chk("mid_rst_out", {16'd0, out}, 32'd0);
        RST = 1'b0;
        count_fill(n, quiet, 1'b1);
        chk("mid_len", n, 32'd4096);
        chk("mid_quiet", {31'd0, quiet}, 32'd1);
        wr(14'h3FFE, 16'h4321);
        rd_chk("post_3ffe", 14'h3FFE, 16'h4321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised, banked, synchronous single-port RAM that generalises the fixed 16K-word Hack data memory to any word width, depth and bank count. It adds a registered read with a valid strobe, a hardware zero-fill sequencer that runs after reset or on request, and a `busy` indication. It sits between the CPU data port and the memory-mapped I/O decode, replacing the fixed-size RAM stack.

## Interface
Parameters:
- `DATA_W`, 16, word width in bits.
- `ADDR_W`, 14, word address width; depth is 2^ADDR_W.
- `BANKS`, 4, number of banks; a power of two, 1 ≤ BANKS ≤ 2^ADDR_W.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `en`  in  1  access strobe, sampled each edge.
- `load`  in  1  with `en`: 1 = write, 0 = read.
- `address`  in  ADDR_W  word address; the top log2(BANKS) bits select the bank, the rest are the in-bank offset.
- `in`  in  DATA_W  write data.
- `clr`  in  1  one-cycle request to zero-fill the whole memory.
- `out`  out  DATA_W  registered read data.
- `out_valid`  out  1  one-cycle pulse; `out` carries the result of the read issued on the previous edge.
- `busy`  out  1  high while zero-fill is running; accesses are ignored.

## Operation
- FSM states are CLEAR and IDLE. `RST` forces CLEAR with the fill counter at 0, whatever the current state, including mid-fill.
- CLEAR: each cycle writes 0 to offset `cnt` in every bank in parallel, then increments `cnt`. When `cnt` = 2^ADDR_W/BANKS − 1 is written, the FSM moves to IDLE and `cnt` returns to 0. `busy` = 1 throughout CLEAR. `en` and `clr` are ignored in CLEAR.
- IDLE: `busy` = 0.
  - `clr` = 1 moves the FSM to CLEAR on the next edge. If `en` is asserted in the same cycle, that access is still performed.
  - `en & load` writes `in` to `address` in the selected bank only.
  - `en & ~load` reads `address`. `out` and `out_valid` are updated on the same edge.
- `out` holds its last value until the next read completes. `out_valid` is 0 in every cycle that has no completing read.
- Read of any address after fill completes returns 0 until that address is written.
- Only the selected bank's write enable rises; all other banks are unchanged.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `busy` = 1 (the fill starts immediately after reset).
- Fill duration is exactly 2^ADDR_W/BANKS cycles after `RST` deasserts. `busy` falls on the edge that writes the last offset. With defaults this is 4096 cycles.
- Read latency: 1 cycle. A read issued at edge N produces `out` and `out_valid` = 1 after edge N.
- Back-to-back reads give one result per cycle. A write followed by a read of the same address on the next edge returns the new data.
- Memory has one port, so read-during-write does not arise. Result precedence for the same-cycle `clr` plus read in IDLE: the read completes normally and `busy` rises on the same edge.

## Configuration
- `BANKED_RAM_WRITE_ECHO_EN`
  - Defined: an IDLE write also drives `out` = `in` and pulses `out_valid`. This is the write-through echo used by the debug monitor.
  - Undefined: writes never touch `out` or `out_valid`.

## Structure
- Shared package `hack_mem_pkg`:
  - default `DATA_W`/`ADDR_W`/`BANKS` constants;
  - the FSM state enum (CLEAR, IDLE);
  - the `clog2`-based bank-select width function.
- One sub-module `ram_bank`: a single bank of 2^ADDR_W/BANKS words with write enable, offset, data in, and registered data out. `banked_ram` instantiates `BANKS` copies.
- `banked_ram` holds the bank decode, the output mux (selected by the registered bank index), the fill counter and FSM, and the valid and echo logic.

## Test plan
- Reset: assert `RST` 2 cycles, release → `busy` = 1 for exactly 4096 cycles, `out` = 0, `out_valid` = 0 throughout; then a read of 0x3FFF returns 0 with `out_valid` pulsed one cycle later.
- Bank isolation: write 0x1234 @0x0005, 0xBEEF @0x1005, 0xCAFE @0x2005, 0x0F0F @0x3005 → reads return each value unchanged; the read of 0x0006 returns 0.
- Back-to-back: write 0xAAAA @0x0100, then read 0x0100 on the next cycle, then read 0x0101 → `out` = 0xAAAA then 0x0000, with `out_valid` high for 2 consecutive cycles.
- `clr` in IDLE: memory holds 0x5555 @0x2000; pulse `clr` with a same-cycle read of 0x2000 → `out` = 0x5555 and `busy` rises on the same edge; after 4096 cycles a read of 0x2000 returns 0; a write issued while `busy` is dropped.
- Reset mid-fill: assert `RST` at fill cycle 1000 → the counter restarts and `busy` stays high for 4096 cycles after release.
- `BANKED_RAM_WRITE_ECHO_EN`: write 0x7E7E @0x0010 → with the macro defined, `out` = 0x7E7E and `out_valid` pulses one cycle later; with it undefined, `out` and `out_valid` are unchanged.
